// File: rtl/instr_enc_loader.sv
// instr_enc_loader: packs decoded RV32I fields into 32-bit instruction words
// and streams them into instruction memory through a single-entry output
// register with valid/ready back-pressure. Bundles with bad immediates or an
// unknown format are swallowed and recorded in a sticky error flag.
module instr_enc_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    input  logic              wr_ready,
    output logic [ADDR_W:0]   count,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_RANGE = 2'd1,
        ERR_ALIGN = 2'd2,
        ERR_FMT   = 2'd3
    } err_t;

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   CNT_MAX  = '1;

    logic        handshake;
    logic        accept;
    logic        bundle_ok;
    logic [31:0] enc_word;
    err_t        chk_code;

    // An immediate fits its field when every bit above the field's sign bit
    // is a copy of that sign bit.
    logic        rng_is;
    logic        rng_b;
    logic        rng_j;

    assign rng_is = (&imm[31:11]) | ~(|imm[31:11]);
    assign rng_b  = (&imm[31:12]) | ~(|imm[31:12]);
    assign rng_j  = (&imm[31:20]) | ~(|imm[31:20]);

    // The output register can take a new word when empty or when it drains
    // this cycle; start blocks intake so its flush is never mixed with a load.
    assign in_ready  = !start && (!wr_en || wr_ready);
    assign accept    = in_valid && in_ready;
    assign handshake = wr_en && wr_ready;
    assign bundle_ok = (chk_code == ERR_NONE);

    // Pack the fields for the selected format and classify the bundle;
    // the range check wins over alignment when both fail.
    always_comb begin
        enc_word = 32'h0;
        chk_code = ERR_NONE;
        case (fmt)
            FMT_R: begin
                enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            FMT_I: begin
                enc_word = {imm[11:0], rs1, funct3, rd, opcode};
                if (!rng_is) chk_code = ERR_RANGE;
            end
            FMT_S: begin
                enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                if (!rng_is) chk_code = ERR_RANGE;
            end
            FMT_B: begin
                enc_word = {imm[12], imm[10:5], rs2, rs1, funct3,
                            imm[4:1], imm[11], opcode};
                if (!rng_b)      chk_code = ERR_RANGE;
                else if (imm[0]) chk_code = ERR_ALIGN;
            end
            FMT_U: begin
                enc_word = {imm[31:12], rd, opcode};
                if (imm[11:0] != 12'h000) chk_code = ERR_ALIGN;
            end
            FMT_J: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                if (!rng_j)      chk_code = ERR_RANGE;
                else if (imm[0]) chk_code = ERR_ALIGN;
            end
            default: begin
                chk_code = ERR_FMT;
            end
        endcase
    end

    // Output register, write pointer, word counter and sticky error; start
    // overrides everything and discards a pending word even if it would drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en    <= 1'b0;
            wr_data  <= 32'h0;
            wr_addr  <= BASE;
            count    <= '0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else if (start) begin
            wr_en    <= 1'b0;
            wr_addr  <= BASE;
            count    <= '0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            if (handshake) begin
                wr_addr <= wr_addr + ADDR_ONE;
                if (count != CNT_MAX) count <= count + CNT_ONE;
            end
            if (accept && bundle_ok) begin
                wr_en   <= 1'b1;
                wr_data <= enc_word;
            end else if (handshake) begin
                wr_en <= 1'b0;
            end
            if (accept && !bundle_ok) begin
                err <= 1'b1;
                if (err_code == ERR_NONE) err_code <= chk_code;
            end
        end
    end

endmodule

// File: tb/tb_instr_enc_loader.sv
// tb_instr_enc_loader: directed scenarios plus a randomized run for
// instr_enc_loader, with a second instance (ADDR_W=2, BASE_ADDR=2) sharing
// the same stimulus to observe pointer wrap.
module tb_instr_enc_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        wr_ready = 1'b0;
    logic [2:0]  fmt = '0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [31:0] imm = '0;

    logic        in_ready, wr_en, err;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic [10:0] count;
    logic [1:0]  err_code;

    logic        w_in_ready, w_wr_en, w_err;
    logic [1:0]  w_wr_addr;
    logic [31:0] w_wr_data;
    logic [2:0]  w_count;
    logic [1:0]  w_err_code;

    int n_cmp = 0;
    int n_bad = 0;

    instr_enc_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .fmt(fmt), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .count(count), .err(err), .err_code(err_code)
    );

    instr_enc_loader #(.ADDR_W(2), .BASE_ADDR(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(w_in_ready), .fmt(fmt), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
        .wr_ready(wr_ready), .count(w_count), .err(w_err), .err_code(w_err_code)
    );

    always #5 clk = ~clk;

    // Reference: bit field of v starting at lo, n bits wide.
    function automatic logic [31:0] bits(input logic [31:0] v, input int lo, input int n);
        return (v >> lo) & ((32'h1 << n) - 32'h1);
    endfunction

    // Reference: error class of a bundle from the numeric immediate value.
    function automatic int ref_check(input logic [2:0] f, input logic [31:0] im);
        int s;
        s = $signed(im);
        if (f > 3'd5) return 3;
        case (f)
            3'd1, 3'd2: if (s < -2048 || s > 2047) return 1;
            3'd3: begin
                if (s < -4096 || s > 4095) return 1;
                if (im % 2 != 0) return 2;
            end
            3'd4: if (im % 4096 != 0) return 2;
            3'd5: begin
                if (s < -1048576 || s > 1048575) return 1;
                if (im % 2 != 0) return 2;
            end
            default: ;
        endcase
        return 0;
    endfunction

    // Reference: instruction word built by placing each field at its bit position.
    function automatic logic [31:0] ref_word(input logic [2:0] f, input logic [6:0] op,
                                             input logic [2:0] f3, input logic [6:0] f7,
                                             input logic [4:0] d, input logic [4:0] s1,
                                             input logic [4:0] s2, input logic [31:0] im);
        logic [31:0] w;
        w = 32'(op);
        case (f)
            3'd0: w = w | (32'(d) << 7) | (32'(f3) << 12) | (32'(s1) << 15)
                        | (32'(s2) << 20) | (32'(f7) << 25);
            3'd1: w = w | (32'(d) << 7) | (32'(f3) << 12) | (32'(s1) << 15)
                        | (bits(im, 0, 12) << 20);
            3'd2: w = w | (bits(im, 0, 5) << 7) | (32'(f3) << 12) | (32'(s1) << 15)
                        | (32'(s2) << 20) | (bits(im, 5, 7) << 25);
            3'd3: w = w | (bits(im, 11, 1) << 7) | (bits(im, 1, 4) << 8)
                        | (32'(f3) << 12) | (32'(s1) << 15) | (32'(s2) << 20)
                        | (bits(im, 5, 6) << 25) | (bits(im, 12, 1) << 31);
            3'd4: w = w | (32'(d) << 7) | (bits(im, 12, 20) << 12);
            3'd5: w = w | (32'(d) << 7) | (bits(im, 12, 8) << 12)
                        | (bits(im, 11, 1) << 20) | (bits(im, 1, 10) << 21)
                        | (bits(im, 20, 1) << 31);
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] cur_word();
        return ref_word(fmt, opcode, funct3, funct7, rd, rs1, rs2, imm);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bundle(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [31:0] im);
        fmt = f; opcode = op; funct3 = f3; funct7 = f7;
        rd = d; rs1 = s1; rs2 = s2; imm = im;
        in_valid = 1'b1;
    endtask

    task automatic pulse_start();
        in_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
        n_cmp++; if (wr_data !== 32'h0) begin n_bad++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
        n_cmp++; if (wr_addr !== 10'd0) begin n_bad++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
        n_cmp++; if (w_wr_addr !== 2'd2) begin n_bad++; $display("FAIL reset_w_wr_addr: got %0d want 2", w_wr_addr); end
        n_cmp++; if (count !== 11'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (err !== 1'b0 || err_code !== 2'd0) begin n_bad++; $display("FAIL reset_err: got %b/%0d want 0/0", err, err_code); end
        rst_n = 1'b1;
        tick();
    endtask

    logic [2:0]  lg_fmt [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    logic [6:0]  lg_op  [6] = '{7'h33, 7'h13, 7'h23, 7'h63, 7'h37, 7'h6F};
    logic [4:0]  lg_rd  [6] = '{5'd8, 5'd10, 5'd0, 5'd0, 5'd10, 5'd10};
    logic [4:0]  lg_rs1 [6] = '{5'd4, 5'd5, 5'd6, 5'd6, 5'd0, 5'd0};
    logic [4:0]  lg_rs2 [6] = '{5'd2, 5'd0, 5'd3, 5'd3, 5'd0, 5'd0};
    logic [31:0] lg_imm [6] = '{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'd4, 32'h1000, 32'h1000};
    logic [31:0] lg_exp [6] = '{32'h00220433, 32'hFFF28513, 32'hFE330E23,
                                32'h00330263, 32'h00001537, 32'h0000156F};

    task automatic test_legal();
        wr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_bundle(lg_fmt[i], lg_op[i], 3'd0, 7'd0, lg_rd[i], lg_rs1[i], lg_rs2[i], lg_imm[i]);
            tick();
            n_cmp++; if (wr_en !== 1'b1) begin n_bad++; $display("FAIL legal_wr_en[%0d]: got %b want 1", i, wr_en); end
            n_cmp++; if (wr_addr !== 10'(i)) begin n_bad++; $display("FAIL legal_addr[%0d]: got %0d want %0d", i, wr_addr, i); end
            n_cmp++; if (wr_data !== lg_exp[i]) begin n_bad++; $display("FAIL legal_data[%0d]: got %h want %h", i, wr_data, lg_exp[i]); end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (count !== 11'd6) begin n_bad++; $display("FAIL legal_count: got %0d want 6", count); end
        n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL legal_drained: got %b want 0", wr_en); end
    endtask

    task automatic test_imm_err();
        logic [31:0] w;
        wr_ready = 1'b1;
        in_valid = 1'b0;
        start = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL start_in_ready: got %b want 0", in_ready); end
        tick();
        start = 1'b0;
        set_bundle(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd2048);
        tick();
        n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL immerr_wr_en: got %b want 0", wr_en); end
        n_cmp++; if (err !== 1'b1 || err_code !== 2'd1) begin n_bad++; $display("FAIL immerr_range: got %b/%0d want 1/1", err, err_code); end
        n_cmp++; if (wr_addr !== 10'd0) begin n_bad++; $display("FAIL immerr_addr: got %0d want 0", wr_addr); end
        set_bundle(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
        tick();
        n_cmp++; if (wr_en !== 1'b0 || err_code !== 2'd1) begin n_bad++; $display("FAIL immerr_sticky: got wr_en=%b code=%0d want 0/1", wr_en, err_code); end
        set_bundle(3'd0, 7'h33, 3'd5, 7'h20, 5'd3, 5'd7, 5'd9, 32'd0);
        w = cur_word();
        tick();
        n_cmp++; if (wr_en !== 1'b1 || wr_addr !== 10'd0 || wr_data !== w) begin n_bad++; $display("FAIL immerr_after: got en=%b addr=%0d data=%h want 1/0/%h", wr_en, wr_addr, wr_data, w); end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (count !== 11'd1) begin n_bad++; $display("FAIL immerr_count: got %0d want 1", count); end
    endtask

    task automatic test_illegal_fmt();
        tick();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        wr_ready = 1'b1;
        set_bundle(3'd6, 7'h33, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL fmt_in_ready_before: got %b want 1", in_ready); end
        tick();
        n_cmp++; if (err_code !== 2'd3 || err !== 1'b1) begin n_bad++; $display("FAIL fmt_code: got %b/%0d want 1/3", err, err_code); end
        n_cmp++; if (wr_en !== 1'b0 || count !== 11'd0) begin n_bad++; $display("FAIL fmt_no_write: got en=%b count=%0d want 0/0", wr_en, count); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL fmt_in_ready_after: got %b want 1", in_ready); end
        in_valid = 1'b0;
    endtask

    task automatic test_back_pressure();
        logic [31:0] wa, wb;
        pulse_start();
        wr_ready = 1'b0;
        set_bundle(3'd1, 7'h13, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 32'd100);
        wa = cur_word();
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_empty: got %b want 1", in_ready); end
        tick();
        set_bundle(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd4, 5'd5, 32'hFFFF_F800);
        wb = cur_word();
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_stall[%0d]: got %b want 0", i, in_ready); end
            tick();
            n_cmp++; if (wr_en !== 1'b1 || wr_addr !== 10'd0 || wr_data !== wa) begin n_bad++; $display("FAIL bp_stable[%0d]: got en=%b addr=%0d data=%h want 1/0/%h", i, wr_en, wr_addr, wr_data, wa); end
        end
        wr_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_release: got %b want 1", in_ready); end
        tick();
        n_cmp++; if (wr_en !== 1'b1 || wr_addr !== 10'd1 || wr_data !== wb) begin n_bad++; $display("FAIL bp_second: got en=%b addr=%0d data=%h want 1/1/%h", wr_en, wr_addr, wr_data, wb); end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (wr_en !== 1'b0 || wr_addr !== 10'd2 || count !== 11'd2) begin n_bad++; $display("FAIL bp_done: got en=%b addr=%0d count=%0d want 0/2/2", wr_en, wr_addr, count); end
    endtask

    task automatic test_wrap();
        logic [31:0] w;
        pulse_start();
        wr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_bundle(3'd0, 7'h33, 3'd0, 7'd0, 5'(i + 1), 5'd1, 5'd2, 32'd0);
            w = cur_word();
            tick();
            n_cmp++; if (w_wr_addr !== 2'((2 + i) % 4) || w_wr_data !== w) begin n_bad++; $display("FAIL wrap_addr[%0d]: got addr=%0d data=%h want %0d/%h", i, w_wr_addr, w_wr_data, (2 + i) % 4, w); end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (w_count !== 3'd5 || w_wr_addr !== 2'd3) begin n_bad++; $display("FAIL wrap_count: got count=%0d addr=%0d want 5/3", w_count, w_wr_addr); end
    endtask

    task automatic test_start_abort();
        pulse_start();
        wr_ready = 1'b1;
        set_bundle(3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0);
        tick();
        in_valid = 1'b0;
        tick();
        set_bundle(3'd7, 7'h33, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0);
        tick();
        wr_ready = 1'b0;
        set_bundle(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h0ABC_D000);
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++; if (wr_en !== 1'b1 || err !== 1'b1 || count !== 11'd1) begin n_bad++; $display("FAIL abort_setup: got en=%b err=%b count=%0d want 1/1/1", wr_en, err, count); end
        start = 1'b1;
        wr_ready = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++; if (wr_en !== 1'b0 || wr_addr !== 10'd0 || count !== 11'd0) begin n_bad++; $display("FAIL abort_flush: got en=%b addr=%0d count=%0d want 0/0/0", wr_en, wr_addr, count); end
        n_cmp++; if (err !== 1'b0 || err_code !== 2'd0) begin n_bad++; $display("FAIL abort_err_clear: got %b/%0d want 0/0", err, err_code); end
        set_bundle(3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0);
        tick();
        in_valid = 1'b0;
        tick();
        set_bundle(3'd6, 7'h33, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0);
        tick();
        wr_ready = 1'b0;
        set_bundle(3'd1, 7'h13, 3'd0, 7'd0, 5'd2, 5'd3, 5'd0, 32'd7);
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (wr_en !== 1'b0 || wr_data !== 32'h0 || wr_addr !== 10'd0) begin n_bad++; $display("FAIL async_out: got en=%b data=%h addr=%0d want 0/0/0", wr_en, wr_data, wr_addr); end
        n_cmp++; if (count !== 11'd0 || err !== 1'b0 || err_code !== 2'd0) begin n_bad++; $display("FAIL async_state: got count=%0d err=%b code=%0d want 0/0/0", count, err, err_code); end
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic        pend, hs, acc, exp_rdy;
        logic [31:0] pword;
        logic [9:0]  eaddr;
        logic [10:0] ecnt;
        logic        eerr;
        logic [1:0]  ecode;
        int          c;
        pulse_start();
        pend = 1'b0; pword = 32'h0; eaddr = '0; ecnt = '0; eerr = 1'b0; ecode = 2'd0;
        repeat (400) begin
            start    = ($urandom_range(0, 49) == 0);
            in_valid = ($urandom_range(0, 2) != 0);
            wr_ready = ($urandom_range(0, 3) != 0);
            fmt      = ($urandom_range(0, 15) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
            opcode   = 7'($urandom);
            funct3   = 3'($urandom);
            funct7   = 7'($urandom);
            rd       = 5'($urandom);
            rs1      = 5'($urandom);
            rs2      = 5'($urandom);
            case ($urandom_range(0, 3))
                0: imm = $urandom;
                1: imm = 32'($signed($urandom_range(0, 4095)) - 2048);
                2: imm = 32'($signed($urandom_range(0, 8191)) - 4096) & 32'hFFFF_FFFE;
                default: imm = $urandom & 32'hFFFF_F000;
            endcase
            #1;
            exp_rdy = !start && (!pend || wr_ready);
            n_cmp++; if (in_ready !== exp_rdy) begin n_bad++; $display("FAIL rnd_in_ready: got %b want %b", in_ready, exp_rdy); end
            n_cmp++; if (wr_en !== pend || wr_addr !== eaddr) begin n_bad++; $display("FAIL rnd_port: got en=%b addr=%0d want %b/%0d", wr_en, wr_addr, pend, eaddr); end
            if (pend) begin
                n_cmp++; if (wr_data !== pword) begin n_bad++; $display("FAIL rnd_data: got %h want %h", wr_data, pword); end
            end
            if (start) begin
                pend = 1'b0; eaddr = '0; ecnt = '0; eerr = 1'b0; ecode = 2'd0;
            end else begin
                hs  = pend && wr_ready;
                acc = in_valid && exp_rdy;
                if (hs) begin
                    eaddr = eaddr + 10'd1;
                    if (ecnt != 11'h7FF) ecnt = ecnt + 11'd1;
                    pend = 1'b0;
                end
                if (acc) begin
                    c = ref_check(fmt, imm);
                    if (c == 0) begin
                        pend  = 1'b1;
                        pword = cur_word();
                    end else begin
                        eerr = 1'b1;
                        if (ecode == 2'd0) ecode = 2'(c);
                    end
                end
            end
            tick();
            n_cmp++; if (count !== ecnt || err !== eerr || err_code !== ecode) begin n_bad++; $display("FAIL rnd_status: got count=%0d err=%b code=%0d want %0d/%b/%0d", count, err, err_code, ecnt, eerr, ecode); end
        end
        start = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_legal();
        test_imm_err();
        test_illegal_fmt();
        test_back_pressure();
        test_wrap();
        test_start_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_enc_loader.md
Name: instr_enc_loader

Overview:
- Streaming RV32I instruction encoder: accepts decoded fields (format, opcode, funct3/funct7, rd/rs1/rs2, 32-bit immediate) and packs them into 32-bit instruction words.
- Inverse of the instruction-field decoder.
- Writes encoded words sequentially into instruction memory through a write port with back-pressure.
- Used by the test/bring-up infrastructure to load programs and to round-trip-check the decoder.

Parameters:
- ADDR_W, 10, word-address width of the instruction memory write port.
- BASE_ADDR, 0, word address loaded into the write pointer on reset and on start.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse: flush pending write, reload pointer, clear count/error.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle this cycle.
- fmt  in  3  format code: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- opcode  in  7  instr[6:0].
- funct3  in  3  instr[14:12] for R/I/S/B.
- funct7  in  7  instr[31:25] for R only.
- rd, rs1, rs2  in  5 each  register fields.
- imm  in  32  signed byte-offset or value immediate, unencoded.
- wr_en  out  1  write request to instruction memory.
- wr_addr  out  ADDR_W  word address.
- wr_data  out  32  encoded instruction.
- wr_ready  in  1  memory accepts the write this cycle.
- count  out  ADDR_W+1  words written since reset/start; saturates at all-ones.
- err  out  1  sticky error flag.
- err_code  out  2  first error seen: 0=none, 1=imm out of range, 2=imm misaligned, 3=illegal fmt.

Behaviour:
- Reset values: wr_en=0, wr_data=0, wr_addr=BASE_ADDR, count=0, err=0, err_code=0.
- Output register holds one word.
  - in_ready = !start && (!wr_en || wr_ready); a full register can be refilled in the cycle it drains.
  - Accept = in_valid && in_ready.
  - Latency: an accepted legal bundle appears on wr_data with wr_en=1 on the next clock edge.
- Write handshake occurs when wr_en && wr_ready on a rising edge. On the handshake:
  - wr_addr increments modulo 2^ADDR_W, wrapping to 0 (not BASE_ADDR).
  - count increments and saturates at all-ones.
- While wr_en=1 && wr_ready=0: wr_en, wr_addr and wr_data must remain stable.
- Encoding (fields unused by a format are ignored):
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- Immediate checks:
  - Range: I/S need imm[31:11] all equal; B needs imm[31:12] all equal; J needs imm[31:20] all equal.
  - Alignment: B/J need imm[0]=0; U needs imm[11:0]=0.
  - Range is checked before alignment; err_code reports the first failing check.
- Error bundle (range, alignment, or fmt 6/7):
  - The bundle is accepted and dropped.
  - No write is issued; wr_addr and count are unchanged.
  - err sets and stays set; err_code is written only if it is currently 0.
  - A pending legal word in the output register is unaffected.
- start:
  - Takes priority over every other event. in_ready=0 during start, so no accept happens that cycle.
  - Next edge: wr_en=0 (a pending word is discarded even if wr_ready=1 that cycle), wr_addr=BASE_ADDR, count=0, err=0, err_code=0.
- rst_n low mid-operation: all state returns to reset values immediately (asynchronous); the pending word is lost.

Test Plan:
- Legal encodes at BASE_ADDR=0, wr_ready=1; expect addresses 0..5:
  - R op=0x33 rd=8 rs1=4 rs2=2 f3=0 f7=0 -> 0x00220433.
  - I op=0x13 rd=10 rs1=5 imm=-1 -> 0xFFF28513.
  - S op=0x23 rs1=6 rs2=3 imm=-4 -> 0xFE330E23.
  - B op=0x63 rs1=6 rs2=3 imm=4 -> 0x00330263.
  - U op=0x37 rd=10 imm=0x1000 -> 0x00001537.
  - J op=0x6F rd=10 imm=0x1000 -> 0x0000156F.
  - Final count=6.
- Immediate errors:
  - I with imm=2048 -> no wr_en, err=1, err_code=1, wr_addr unchanged.
  - Then B with imm=3 -> dropped, err_code stays 1.
  - Then a legal R is written at the unchanged address.
- Illegal fmt=6 after reset -> err_code=3, no write, in_ready stays 1.
- Back-pressure: wr_ready=0 for 4 cycles with a second bundle valid -> wr_en/wr_addr/wr_data stable, in_ready=0. Release -> back-to-back writes at consecutive addresses, one per cycle.
- Wrap: ADDR_W=2, BASE_ADDR=2, write 5 words -> addresses 2,3,0,1,2; count=5.
- start pulse while wr_en=1, wr_ready=0 -> next cycle wr_en=0, wr_addr=BASE_ADDR, count=0, err=0. Async rst_n low mid-stall -> all outputs at reset values before the next clock edge.
